// File: rtl/trigger_capture.sv
// trigger_capture: circular pre-trigger history, programmable post-trigger capture,
// and oldest-first readout through a sync RAM, an output register and a one-word skid.
module trigger_capture #(
    parameter int SDW = 32,
    parameter int SEW = 2,
    parameter int MAW = 10,
    parameter int CW  = 16,
    parameter int BAW = 2,
    parameter int BDW = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             bus_wready,
    input  logic             bus_wvalid,
    input  logic [BAW-1:0]   bus_waddr,
    input  logic [BDW-1:0]   bus_wdata,
    output logic             sti_tready,
    input  logic             sti_tvalid,
    input  logic [SEW-1:0]   sti_tevent,
    input  logic [SDW-1:0]   sti_tdata,
    input  logic             sto_tready,
    output logic             sto_tvalid,
    output logic             sto_tlast,
    output logic [SDW-1:0]   sto_tdata,
    output logic [1:0]       sts_state,
    output logic             sts_abort
);

    localparam int DEPTH = 2 ** MAW;
    localparam logic [MAW:0]   FILL_MAX = (MAW+1)'(DEPTH);
    localparam logic [MAW:0]   FILL_ONE = (MAW+1)'(1);
    localparam logic [MAW:0]   FILL_ZERO = (MAW+1)'(0);
    localparam logic [MAW-1:0] PTR_ONE  = MAW'(1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t           r_state;
    logic [MAW-1:0]   r_wptr;
    logic [MAW-1:0]   r_rptr;
    logic [MAW:0]     r_fill;
    logic [MAW:0]     r_rem;
    logic [CW-1:0]    r_cfg_post;
    logic [CW-1:0]    r_post_cnt;
    logic             r_abort;
    logic [SDW-1:0]   r_mem [DEPTH];
    logic [SDW-1:0]   r_rdata;
    logic             r_rvalid;
    logic             r_rlast;
    logic             r_ovalid;
    logic             r_olast;
    logic [SDW-1:0]   r_odata;
    logic             r_svalid;
    logic             r_slast;
    logic [SDW-1:0]   r_sdata;

    logic             w_ctl_wr;
    logic             w_sw_abort;
    logic             w_arm;
    logic             w_cfg_wr;
    logic             w_capturing;
    logic             w_sti_xfer;
    logic             w_ev_abort;
    logic             w_store;
    logic             w_trig;
    logic             w_post_done;
    logic             w_enter_read;
    logic [MAW-1:0]   w_wptr_nxt;
    logic [MAW:0]     w_fill_nxt;
    logic [MAW-1:0]   w_rd_start;
    logic             w_pop;
    logic [1:0]       w_occ;
    logic             w_rd_en;
    logic             w_unused;

    assign w_ctl_wr     = bus_wvalid && (bus_waddr == BAW'(0));
    assign w_sw_abort   = w_ctl_wr && bus_wdata[1];
    assign w_arm        = w_ctl_wr && bus_wdata[0] && !bus_wdata[1] && (r_state == ST_IDLE);
    // cfg_post only changes between captures so a running capture keeps its count
    assign w_cfg_wr     = bus_wvalid && (bus_waddr == BAW'(1)) && (r_state == ST_IDLE);
    assign w_capturing  = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_sti_xfer   = sti_tvalid && w_capturing;
    assign w_ev_abort   = w_sti_xfer && sti_tevent[1];
    assign w_store      = w_sti_xfer && !sti_tevent[1];
    assign w_trig       = w_store && (r_state == ST_ARMED) && sti_tevent[0];
    assign w_post_done  = w_store && (r_state == ST_POST) && (r_post_cnt == CNT_ONE);
    assign w_enter_read = (w_trig && (r_cfg_post == CNT_ZERO)) || w_post_done;
    assign w_wptr_nxt   = r_wptr + PTR_ONE;
    assign w_fill_nxt   = (r_fill == FILL_MAX) ? r_fill : (r_fill + FILL_ONE);
    // oldest stored sample once the current one is written (fill==DEPTH wraps to wptr)
    assign w_rd_start   = w_wptr_nxt - w_fill_nxt[MAW-1:0];

    // Readout credit: words in output reg + skid + RAM stage after this cycle's pop
    assign w_pop   = r_ovalid && sto_tready;
    assign w_occ   = {1'b0, r_ovalid} + {1'b0, r_svalid} + {1'b0, r_rvalid} - {1'b0, w_pop};
    assign w_rd_en = (r_state == ST_READ) && (r_rem != FILL_ZERO) && (w_occ < 2'd2) && !w_sw_abort;

    assign w_unused = ^bus_wdata[BDW-1:CW];

    assign bus_wready = 1'b1;
    assign sti_tready = (r_state != ST_READ);
    assign sto_tvalid = r_ovalid;
    assign sto_tlast  = r_olast;
    assign sto_tdata  = r_odata;
    assign sts_state  = r_state;
    assign sts_abort  = r_abort;

    // Post-trigger count configuration register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cfg_post <= CNT_ZERO;
        end else if (w_cfg_wr) begin
            r_cfg_post <= bus_wdata[CW-1:0];
        end
    end

    // Sample buffer: writes stored samples, registered read feeds the readout pipeline.
    always_ff @(posedge clk) begin
        if (rst && w_store) begin
            r_mem[r_wptr] <= sti_tdata;
        end
        if (w_rd_en) begin
            r_rdata <= r_mem[r_rptr];
        end
    end

    // Capture FSM, write/read pointers and output register with skid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fill     <= FILL_ZERO;
            r_rem      <= FILL_ZERO;
            r_post_cnt <= CNT_ZERO;
            r_abort    <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_ovalid   <= 1'b0;
            r_olast    <= 1'b0;
            r_odata    <= '0;
            r_svalid   <= 1'b0;
            r_slast    <= 1'b0;
            r_sdata    <= '0;
        end else if (w_sw_abort) begin
            r_state  <= ST_IDLE;
            r_abort  <= 1'b1;
            r_rem    <= FILL_ZERO;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_ovalid <= 1'b0;
            r_olast  <= 1'b0;
            r_svalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arm) begin
                        r_state <= ST_ARMED;
                        r_fill  <= FILL_ZERO;
                        r_abort <= 1'b0;
                    end
                end
                ST_ARMED, ST_POST: begin
                    if (w_ev_abort) begin
                        r_state <= ST_IDLE;
                        r_abort <= 1'b1;
                    end else if (w_store) begin
                        r_wptr <= w_wptr_nxt;
                        r_fill <= w_fill_nxt;
                        if (w_trig) begin
                            r_post_cnt <= r_cfg_post;
                        end else if (r_state == ST_POST) begin
                            r_post_cnt <= r_post_cnt - CNT_ONE;
                        end
                        if (w_enter_read) begin
                            r_state <= ST_READ;
                            r_rptr  <= w_rd_start;
                            r_rem   <= w_fill_nxt;
                        end else if (w_trig) begin
                            r_state <= ST_POST;
                        end
                    end
                end
                ST_READ: begin
                    if (w_rd_en) begin
                        r_rptr <= r_rptr + PTR_ONE;
                        r_rem  <= r_rem - FILL_ONE;
                    end
                    r_rvalid <= w_rd_en;
                    r_rlast  <= w_rd_en && (r_rem == FILL_ONE);
                    if (w_pop && r_olast) begin
                        r_state  <= ST_IDLE;
                        r_ovalid <= 1'b0;
                        r_olast  <= 1'b0;
                        r_svalid <= 1'b0;
                    end else if (w_pop) begin
                        if (r_svalid) begin
                            r_odata  <= r_sdata;
                            r_olast  <= r_slast;
                            r_svalid <= r_rvalid;
                            r_sdata  <= r_rdata;
                            r_slast  <= r_rlast;
                        end else if (r_rvalid) begin
                            r_odata <= r_rdata;
                            r_olast <= r_rlast;
                        end else begin
                            r_ovalid <= 1'b0;
                        end
                    end else if (r_rvalid) begin
                        if (!r_ovalid) begin
                            r_ovalid <= 1'b1;
                            r_odata  <= r_rdata;
                            r_olast  <= r_rlast;
                        end else begin
                            r_svalid <= 1'b1;
                            r_sdata  <= r_rdata;
                            r_slast  <= r_rlast;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_capture.sv
// Self-checking bench for trigger_capture (DEPTH=16) against a queue-based capture model.
module tb_trigger_capture;

    localparam int SDW = 32;
    localparam int SEW = 2;
    localparam int MAW = 4;
    localparam int CW  = 16;
    localparam int BAW = 2;
    localparam int BDW = 32;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             bus_wready;
    logic             bus_wvalid;
    logic [BAW-1:0]   bus_waddr;
    logic [BDW-1:0]   bus_wdata;
    logic             sti_tready;
    logic             sti_tvalid;
    logic [SEW-1:0]   sti_tevent;
    logic [SDW-1:0]   sti_tdata;
    logic             sto_tready;
    logic             sto_tvalid;
    logic             sto_tlast;
    logic [SDW-1:0]   sto_tdata;
    logic [1:0]       sts_state;
    logic             sts_abort;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: capture mode (0 idle,1 armed,2 post,3 read) and stored history
    int          m_state;
    int          m_cnt;
    int          m_cfg_post;
    bit          m_abort;
    logic [31:0] hist[$];

    always #5 clk = ~clk;

    trigger_capture #(
        .SDW(SDW), .SEW(SEW), .MAW(MAW), .CW(CW), .BAW(BAW), .BDW(BDW)
    ) dut (
        .clk(clk), .rst(rst),
        .bus_wready(bus_wready), .bus_wvalid(bus_wvalid), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
        .sti_tready(sti_tready), .sti_tvalid(sti_tvalid), .sti_tevent(sti_tevent), .sti_tdata(sti_tdata),
        .sto_tready(sto_tready), .sto_tvalid(sto_tvalid), .sto_tlast(sto_tlast), .sto_tdata(sto_tdata),
        .sts_state(sts_state), .sts_abort(sts_abort)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_cnt      = 0;
        m_cfg_post = 0;
        m_abort    = 1'b0;
        hist.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        bus_wvalid = 1'b0;
        sti_tvalid = 1'b0;
        sto_tready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] data);
        @(negedge clk);
        sti_tvalid = 1'b0;
        bus_wvalid = 1'b1;
        bus_waddr  = addr[1:0];
        bus_wdata  = data;
        if (addr == 0) begin
            if (data[1]) begin
                m_state = 0;
                m_abort = 1'b1;
            end else if (data[0] && m_state == 0) begin
                m_state = 1;
                m_abort = 1'b0;
                hist.delete();
            end
        end else if (addr == 1 && m_state == 0) begin
            m_cfg_post = int'(data[15:0]);
        end
        @(negedge clk);
        bus_wvalid = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
        sti_tvalid = 1'b0;
        bus_wvalid = 1'b0;
    endtask

    // One sample offered for the coming edge; the model applies the capture rules.
    task automatic send(input logic [31:0] data, input logic [1:0] ev);
        @(negedge clk);
        bus_wvalid = 1'b0;
        check_val("sti_tready", sti_tready, (m_state != 3));
        sti_tvalid = 1'b1;
        sti_tdata  = data;
        sti_tevent = ev;
        if (m_state == 1 || m_state == 2) begin
            if (ev[1]) begin
                m_state = 0;
                m_abort = 1'b1;
            end else begin
                hist.push_back(data);
                if (hist.size() > DEPTH) void'(hist.pop_front());
                if (m_state == 1 && ev[0]) begin
                    m_cnt   = m_cfg_post;
                    m_state = (m_cfg_post == 0) ? 3 : 2;
                end else if (m_state == 2) begin
                    m_cnt--;
                    if (m_cnt == 0) m_state = 3;
                end
            end
        end
    endtask

    // Drain the readout; mode 0 always ready, 1 toggling, 2 random. max_words<0 drains fully.
    task automatic read_out(input int mode, input int max_words);
        logic [31:0] exp_q[$];
        int          n;
        int          idx = 0;
        int          lat = 0;
        int          iter = 0;
        bit          seen = 1'b0;
        bit          held = 1'b0;
        bit          tog = 1'b0;
        bit          done = 1'b0;
        bit          rdy;
        logic [31:0] held_d;
        logic        held_l;
        exp_q = hist;
        n = exp_q.size();
        while (!done) begin
            @(negedge clk);
            sti_tvalid = 1'b0;
            bus_wvalid = 1'b0;
            iter++;
            check_val("sti_tready_read", sti_tready, 1'b0);
            if (held) begin
                check_val("hold_valid", sto_tvalid, 1'b1);
                check_val("hold_data", sto_tdata, held_d);
                check_val("hold_last", sto_tlast, held_l);
            end
            if (max_words >= 0 && idx == max_words) begin
                sto_tready = 1'b0;
                return;
            end
            if (!sto_tvalid && !seen) lat++;
            tog = ~tog;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            sto_tready = rdy;
            if (sto_tvalid) begin
                if (!seen) begin
                    seen = 1'b1;
                    check_val("first_latency", lat, 2);
                end
                if (rdy) begin
                    check_val("rd_data", sto_tdata, (idx < n) ? exp_q[idx] : 32'hDEAD_BEEF);
                    check_val("rd_last", sto_tlast, (idx == n - 1));
                    idx++;
                    held = 1'b0;
                    if (sto_tlast || idx >= n) done = 1'b1;
                end else begin
                    held   = 1'b1;
                    held_d = sto_tdata;
                    held_l = sto_tlast;
                end
            end
            if (!done && iter > 300) begin
                check_val("read_timeout", idx, n);
                done = 1'b1;
            end
        end
        check_val("rd_count", idx, n);
        @(negedge clk);
        sto_tready = 1'b0;
        m_state = 0;
        check_val("post_read_state", sts_state, 2'd0);
        check_val("post_read_valid", sto_tvalid, 1'b0);
    endtask

    task automatic check_aborted(input string tag);
        gap();
        check_val({tag, "_state"}, sts_state, 2'd0);
        check_val({tag, "_abort"}, sts_abort, 1'b1);
        check_val({tag, "_valid"}, sto_tvalid, 1'b0);
    endtask

    initial begin
        rst        = 1'b0;
        bus_wvalid = 1'b0;
        bus_waddr  = '0;
        bus_wdata  = '0;
        sti_tvalid = 1'b0;
        sti_tevent = '0;
        sti_tdata  = '0;
        sto_tready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_state", sts_state, 2'd0);
        check_val("rst_valid", sto_tvalid, 1'b0);
        check_val("rst_last", sto_tlast, 1'b0);
        check_val("rst_data", sto_tdata, 32'd0);
        check_val("rst_abort", sts_abort, 1'b0);
        check_val("rst_wready", bus_wready, 1'b1);
        check_val("rst_tready", sti_tready, 1'b1);
        rst = 1'b1;

        // 1: post=3, trigger on 5 -> 0..8
        cfg_write(1, 32'd3);
        cfg_write(0, 32'd1);
        check_val("t1_armed", sts_state, 2'd1);
        for (int v = 0; v < 10 && m_state != 3; v++) send(v, (v == 5) ? 2'b01 : 2'b00);
        read_out(0, -1);

        // 2: post=4, trigger on 30 of 0..39 -> 19..34
        cfg_write(1, 32'd4);
        cfg_write(0, 32'd1);
        for (int v = 0; v < 40 && m_state != 3; v++) send(v, (v == 30) ? 2'b01 : 2'b00);
        read_out(0, -1);

        // 3: trigger and abort on the same sample
        cfg_write(0, 32'd1);
        send(32'h55, 2'b11);
        check_aborted("t3");
        repeat (3) begin
            gap();
            check_val("t3_no_valid", sto_tvalid, 1'b0);
        end

        // 4: toggling readout ready
        cfg_write(1, 32'd2);
        cfg_write(0, 32'd1);
        check_val("t4_abort_clr", sts_abort, 1'b0);
        for (int v = 0; v < 12 && m_state != 3; v++) send($urandom, (v == 6) ? 2'b01 : 2'b00);
        read_out(1, -1);

        // 5: post=0, trigger on first sample
        cfg_write(1, 32'd0);
        cfg_write(0, 32'd1);
        send(32'hABCD_1234, 2'b01);
        read_out(0, -1);

        // software abort during POST
        cfg_write(1, 32'd6);
        cfg_write(0, 32'd1);
        send(32'h1, 2'b01);
        send(32'h2, 2'b00);
        cfg_write(0, 32'd2);
        check_val("swab_state", sts_state, 2'd0);
        check_val("swab_abort", sts_abort, 1'b1);

        // 6: ARM ignored in POST, reset during readout
        cfg_write(1, 32'd5);
        cfg_write(0, 32'd1);
        for (int v = 0; v < 4; v++) send(100 + v, (v == 1) ? 2'b01 : 2'b00);
        cfg_write(0, 32'd1);
        check_val("t6_arm_in_post", sts_state, 2'd2);
        for (int v = 4; v < 20 && m_state != 3; v++) send(100 + v, 2'b00);
        read_out(0, 3);
        rst = 1'b0;
        @(negedge clk);
        check_val("t6_rst_valid", sto_tvalid, 1'b0);
        check_val("t6_rst_state", sts_state, 2'd0);
        check_val("t6_rst_data", sto_tdata, 32'd0);
        rst = 1'b1;
        model_reset();

        // randomized captures with gaps, random ready, occasional aborts
        for (int it = 0; it < 12; it++) begin
            int pre;
            cfg_write(1, $urandom_range(0, 20));
            cfg_write(0, 32'd1);
            pre = $urandom_range(0, 25);
            for (int k = 0; k < pre && m_state == 1; k++) begin
                if ($urandom_range(0, 4) == 0) gap();
                send($urandom, ($urandom_range(0, 40) == 0) ? 2'b10 : 2'b00);
            end
            if (m_state == 1) send($urandom, 2'b01);
            while (m_state == 2) begin
                if ($urandom_range(0, 4) == 0) gap();
                send($urandom, ($urandom_range(0, 40) == 0) ? 2'b10 : 2'($urandom_range(0, 1)));
            end
            if (m_state == 3) read_out(2, -1);
            else check_aborted("rnd_abort");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
